// File: rtl/lu_pkg.sv
// Shared definitions for the bit-serial logic unit driver: opcode encoding
// and the controller state encoding.
package lu_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lu_bit.sv
// 1-bit logic unit: combines one x/y bit pair according to the 3-bit select
// {e2,e1,e0}.
module lu_bit
  import lu_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic e2,
  input  logic e1,
  input  logic e0,
  output logic w
);

  always_comb begin
    w = 1'b0;
    case ({e2, e1, e0})
      OP_NOT:  w = ~x;
      OP_AND:  w = x & y;
      OP_NAND: w = ~(x & y);
      OP_XOR:  w = x ^ y;
      OP_XNOR: w = ~(x ^ y);
      OP_OR:   w = x | y;
      OP_NOR:  w = ~(x | y);
      OP_ZERO: w = 1'b0;
      default: w = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_serial.sv
// Bit-serial driver: accepts WIDTH-bit operands, streams them LSB first
// through lu_bit and returns the assembled result over a valid/ready handshake.
module lu_serial
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_next;
  logic [2:0]       op_q;
  logic [CW-1:0]    count;
  logic             w;
  logic             accept;

  lu_bit u_bit (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .e2 (op_q[2]),
    .e1 (op_q[1]),
    .e0 (op_q[0]),
    .w  (w)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // New bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB result.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign result_next = w;
    end else begin : g_wide
      assign result_next = {w, result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      count  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            count <= '0;
          end
        end
        RUN: begin
          result <= result_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          count  <= count + CW'(1);
          if (count == LAST) zero <= (result_next == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
